// File: rtl/hub75_panel_driver_if.sv
// Pixel write bus from the UDP panel writer into one hub75_panel_driver slot.
interface hub75_panel_driver_if;
    logic [7:0]  ctrl_en;
    logic [15:0] ctrl_addr;
    logic [23:0] ctrl_wdat;

    modport master (output ctrl_en, ctrl_addr, ctrl_wdat);
    modport slave  (input  ctrl_en, ctrl_addr, ctrl_wdat);
endinterface

// File: rtl/hub75_panel_driver.sv
// 64x64 1/32-scan HUB75 driver: dual framebuffer fed by the ctrl_* bus, BCM scan-out.
// Optional macro GAMMA_CORRECT_EN adds a registered gamma-2.2 ROM on the write path.
module hub75_panel_driver #(
    parameter int PANEL_SEL = 0,
    parameter int BITS      = 8,
    parameter int DISP_BASE = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    hub75_panel_driver_if.slave  ctrl,
    output logic                 hub75_r0,
    output logic                 hub75_g0,
    output logic                 hub75_b0,
    output logic                 hub75_r1,
    output logic                 hub75_g1,
    output logic                 hub75_b1,
    output logic [4:0]           hub75_addr,
    output logic                 hub75_clk,
    output logic                 hub75_lat,
    output logic                 hub75_oe_n,
    output logic                 frame_sync
);
    localparam int DISP_MAX = DISP_BASE << (BITS - 1);
    localparam int CNT_W    = ($clog2(DISP_MAX) > 8) ? $clog2(DISP_MAX) : 8;
    localparam int PLANE_W  = (BITS > 1) ? $clog2(BITS) : 1;
    localparam int LSB      = 8 - BITS;

    typedef enum logic [1:0] {SHIFT, LATCH, DISPLAY} scan_state_t;

    scan_state_t        state;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   disp_last;
    logic [4:0]         row;
    logic [PLANE_W-1:0] plane;
    logic               data_en;

    logic               wr_en;
    logic               wr_lower;
    logic [10:0]        wr_idx;
    logic [23:0]        wr_data;
    logic [10:0]        rd_idx;
    logic [23:0]        rd_upper;
    logic [23:0]        rd_lower;

    logic               ctrl_unused;
    assign ctrl_unused = ^{ctrl.ctrl_addr[15:12], ctrl.ctrl_en};

`ifdef GAMMA_CORRECT_EN
    typedef logic [7:0] gamma_lut_t [256];

    // Truncating conversion, so 0x80 maps to 0x37 while 0x00/0xFF stay fixed.
    function automatic gamma_lut_t build_gamma();
        gamma_lut_t lut;
        for (int i = 0; i < 256; i++)
            lut[i] = 8'($rtoi(255.0 * ((real'(i) / 255.0) ** 2.2)));
        return lut;
    endfunction

    localparam gamma_lut_t GAMMA = build_gamma();

    always_ff @(posedge clock) begin
        if (reset) wr_en <= 1'b0;
        else       wr_en <= ctrl.ctrl_en[PANEL_SEL];
        wr_lower <= ctrl.ctrl_addr[11];
        wr_idx   <= ctrl.ctrl_addr[10:0];
        wr_data  <= {GAMMA[ctrl.ctrl_wdat[23:16]],
                     GAMMA[ctrl.ctrl_wdat[15:8]],
                     GAMMA[ctrl.ctrl_wdat[7:0]]};
    end
`else
    assign wr_en    = ctrl.ctrl_en[PANEL_SEL];
    assign wr_lower = ctrl.ctrl_addr[11];
    assign wr_idx   = ctrl.ctrl_addr[10:0];
    assign wr_data  = ctrl.ctrl_wdat;
`endif

    logic [23:0] fb_upper [2048];
    logic [23:0] fb_lower [2048];

    // NOTE: the framebuffer arrays are never reset, so they map onto block RAM;
    // only the write strobe is qualified by reset.
    always_ff @(posedge clock) begin
        if (wr_en && !reset && !wr_lower) fb_upper[wr_idx] <= wr_data;
        rd_upper <= fb_upper[rd_idx];
    end

    always_ff @(posedge clock) begin
        if (wr_en && !reset && wr_lower) fb_lower[wr_idx] <= wr_data;
        rd_lower <= fb_lower[rd_idx];
    end

    // Column advances every second SHIFT cycle; read data lands one cycle later.
    assign rd_idx = {row, cnt[6:1]};

    logic [2:0] bit_sel;
    logic [7:0] up_r, up_g, up_b, lo_r, lo_g, lo_b;

    // NOTE: every always_comb output gets a value on every path, so no latches.
    always_comb begin
        bit_sel   = 3'(LSB + int'(plane));
        disp_last = CNT_W'((DISP_BASE << plane) - 1);
        up_r      = rd_upper[23:16];
        up_g      = rd_upper[15:8];
        up_b      = rd_upper[7:0];
        lo_r      = rd_lower[23:16];
        lo_g      = rd_lower[15:8];
        lo_b      = rd_lower[7:0];
        hub75_r0  = data_en & up_r[bit_sel];
        hub75_g0  = data_en & up_g[bit_sel];
        hub75_b0  = data_en & up_b[bit_sel];
        hub75_r1  = data_en & lo_r[bit_sel];
        hub75_g1  = data_en & lo_g[bit_sel];
        hub75_b1  = data_en & lo_b[bit_sel];
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= SHIFT;
            cnt        <= '0;
            row        <= '0;
            plane      <= '0;
            data_en    <= 1'b0;
            hub75_clk  <= 1'b0;
            hub75_lat  <= 1'b0;
            hub75_oe_n <= 1'b1;
            hub75_addr <= '0;
            frame_sync <= 1'b0;
        end else begin
            frame_sync <= 1'b0;
            unique case (state)
                SHIFT: begin
                    if (cnt == CNT_W'(128)) begin
                        state      <= LATCH;
                        cnt        <= '0;
                        data_en    <= 1'b0;
                        hub75_clk  <= 1'b0;
                        hub75_lat  <= 1'b1;
                        hub75_addr <= row;
                    end else begin
                        cnt       <= cnt + 1'b1;
                        data_en   <= 1'b1;
                        hub75_clk <= cnt[0];
                    end
                end
                LATCH: begin
                    if (cnt == '0) begin
                        cnt       <= CNT_W'(1);
                        hub75_lat <= 1'b0;
                    end else begin
                        state      <= DISPLAY;
                        cnt        <= '0;
                        hub75_oe_n <= 1'b0;
                    end
                end
                DISPLAY: begin
                    if (cnt == disp_last) begin
                        state      <= SHIFT;
                        cnt        <= '0;
                        hub75_oe_n <= 1'b1;
                        if (plane == PLANE_W'(BITS - 1)) begin
                            plane      <= '0;
                            row        <= row + 1'b1;
                            frame_sync <= (row == 5'd31);
                        end else begin
                            plane <= plane + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= SHIFT;
            endcase
        end
    end
endmodule

// File: tb/tb_hub75_panel_driver.sv
// Directed bench for hub75_panel_driver: reset values, pixel plane bits, BCM timing, frame_sync.
module tb_hub75_panel_driver;
    localparam int         PANEL_SEL = 2;
    localparam int         BITS      = 8;
    localparam int         DISP_BASE = 4;
    localparam logic [7:0] SEL_MASK  = 8'(1 << PANEL_SEL);
    localparam int         FRAME_CYC = 32 * (8 * 131 + 1020);

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       r0, g0, b0, r1, g1, b1;
    logic [4:0] addr;
    logic       hclk, lat, oe_n, fsync;

    hub75_panel_driver_if bus ();

    hub75_panel_driver #(
        .PANEL_SEL (PANEL_SEL),
        .BITS      (BITS),
        .DISP_BASE (DISP_BASE)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .ctrl       (bus),
        .hub75_r0   (r0),
        .hub75_g0   (g0),
        .hub75_b0   (b0),
        .hub75_r1   (r1),
        .hub75_g1   (g1),
        .hub75_b1   (b1),
        .hub75_addr (addr),
        .hub75_clk  (hclk),
        .hub75_lat  (lat),
        .hub75_oe_n (oe_n),
        .frame_sync (fsync)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int fails  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic write_px(input int x, input int y, input logic [23:0] data, input logic [7:0] en);
        bus.ctrl_en   = en;
        bus.ctrl_addr = {4'h0, 6'(y), 6'(x)};
        bus.ctrl_wdat = data;
        @(posedge clock);
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_rgb"},  32'({r0, g0, b0, r1, g1, b1}), 32'd0);
        check({tag, "_clk"},  32'(hclk),  32'd0);
        check({tag, "_lat"},  32'(lat),   32'd0);
        check({tag, "_oe_n"}, 32'(oe_n),  32'd1);
        check({tag, "_addr"}, 32'(addr),  32'd0);
        check({tag, "_fsync"}, 32'(fsync), 32'd0);
    endtask

    // Hand-listed framebuffer contents after the write phase.
    function automatic logic [23:0] exp_pixel(input int y, input int x);
`ifdef GAMMA_CORRECT_EN
        if (y == 0 && x == 0)   return 24'h37FF00;
`else
        if (y == 3 && x == 5)   return 24'h800000;
        if (y == 40 && x == 63) return 24'h0000FF;
        if (y == 12 && x == 33) return 24'h5AC301;
        if (y == 63 && x == 0)  return 24'h018000;
`endif
        return 24'h000000;
    endfunction

    initial begin
        int          seg;
        int          k;
        int          col;
        int          oe_low;
        int          row;
        int          plane;
        logic        prev_clk;
        logic        prev_oe;
        logic        done;
        logic [23:0] px_u;
        logic [23:0] px_l;
        logic [5:0]  exp6;

        bus.ctrl_en   = 8'h00;
        bus.ctrl_addr = 16'h0000;
        bus.ctrl_wdat = 24'h000000;
        reset         = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        check_reset_values("por");
        reset = 1'b0;

        for (int y = 0; y < 64; y++)
            for (int x = 0; x < 64; x++)
                write_px(x, y, 24'h000000, SEL_MASK);
`ifdef GAMMA_CORRECT_EN
        write_px(0, 0, 24'h80FF00, SEL_MASK);
`else
        write_px(5, 3, 24'h800000, SEL_MASK);
        write_px(63, 40, 24'h0000FF, SEL_MASK);
        write_px(33, 12, 24'h5AC301, SEL_MASK);
        write_px(0, 63, 24'h018000, SEL_MASK);
`endif
        write_px(10, 3, 24'hFFFFFF, ~SEL_MASK);
        bus.ctrl_en = 8'h00;
        repeat (2) @(posedge clock);
        #1;

        for (int i = 0; i < 5000 && !(oe_n === 1'b0 && addr != 5'd0); i++) begin
            @(posedge clock);
            #1;
        end
        check("pre_reset_in_display", 32'(oe_n), 32'd0);

        // Reset mid-DISPLAY with a write offered on the first reset cycle.
        reset         = 1'b1;
        bus.ctrl_en   = SEL_MASK;
        bus.ctrl_addr = {4'h0, 6'd3, 6'd7};
        bus.ctrl_wdat = 24'hFFFFFF;
        @(posedge clock);
        #1;
        bus.ctrl_en = 8'h00;
        check_reset_values("mid_rst");
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;

        seg      = 0;
        k        = 0;
        col      = 0;
        oe_low   = 0;
        prev_clk = 1'b0;
        prev_oe  = 1'b1;
        done     = 1'b0;
        for (int cyc = 0; cyc < FRAME_CYC + 100 && !done; cyc++) begin
            if (prev_oe === 1'b0 && oe_n === 1'b1) begin
                check($sformatf("oe_len_p%0d", seg % BITS), 32'(oe_low), 32'(DISP_BASE << (seg % BITS)));
                seg++;
                k      = 0;
                col    = 0;
                oe_low = 0;
            end
            row   = (seg / BITS) % 32;
            plane = seg % BITS;

            check("frame_sync", 32'(fsync), 32'(seg == 256 && k == 0));
            if (oe_n === 1'b0) begin
                oe_low++;
                check("lat_while_oe", 32'(lat), 32'd0);
                check("clk_while_oe", 32'(hclk), 32'd0);
            end
            if (hclk === 1'b1 && prev_clk === 1'b0) begin
                if (col < 64) begin
                    px_u = exp_pixel(row, col);
                    px_l = exp_pixel(row + 32, col);
                    exp6 = {px_u[16 + plane], px_u[8 + plane], px_u[plane],
                            px_l[16 + plane], px_l[8 + plane], px_l[plane]};
                    check($sformatf("rgb_r%0d_p%0d_c%0d", row, plane, col),
                          32'({r0, g0, b0, r1, g1, b1}), 32'(exp6));
                end
                col++;
            end
            if (lat === 1'b1) begin
                check($sformatf("lat_k_s%0d", seg), 32'(k), 32'd129);
                check($sformatf("lat_cols_s%0d", seg), 32'(col), 32'd64);
                check($sformatf("lat_addr_s%0d", seg), 32'(addr), 32'(row));
            end
            if (seg == 256 && k == 0) done = 1'b1;

            prev_clk = hclk;
            prev_oe  = oe_n;
            k++;
            @(posedge clock);
            #1;
        end
        check("frame_reached", 32'(seg), 32'd256);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end
endmodule
